sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in, parallel-out receiver. It is the far end of the team's parallel-load serial-shift transmitter.
- It rebuilds WIDTH-bit words from a 1-bit serial stream that advances on en_shift strobes. Bit order is selectable: LSB-first (transmitter shifting right) or MSB-first (transmitter shifting left).
- Each completed word is presented on a valid/ready output port with a single holding register and overrun detection.

Parameters:
- WIDTH, 8, word width in bits; must be >= 2.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_shift  input  1  sample strobe; serial_in is captured on a rising clk edge where en_shift=1.
- serial_in  input  1  serial data bit.
- right_left  input  1  bit order: 1 = LSB-first, 0 = MSB-first; sampled only on the first bit of a word.
- clear  input  1  synchronous abort of the partial word and clear of the overrun flag.
- out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
- out_data  output  WIDTH  last completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- busy  output  1  a partial word is in progress (bit_cnt != 0).
- bit_cnt  output  $clog2(WIDTH+1)  number of bits collected in the current word.
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - shift_reg=0, bit_cnt=0, dir_lat=0.
  - out_data=0, out_valid=0, overrun=0, busy=0.
  - Reset mid-word discards the partial word and any held word.
- Direction latch:
  - On a capture with bit_cnt==0, dir_lat <= right_left, and that bit's placement uses right_left directly.
  - Later captures in the same word use dir_lat. Changes to right_left mid-word are ignored.
- Capture when en_shift=1 and clear=0:
  - LSB-first: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}.
  - MSB-first: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
  - bit_cnt increments by 1.
- Word completion (capture with bit_cnt==WIDTH-1):
  - bit_cnt wraps to 0.
  - The assembled word, including the current bit, is the candidate word.
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: out_data <= candidate and out_valid <= 1 on that edge. Latency is one edge after the WIDTH-th strobe.
  - If out_valid=1 and out_ready=0: the candidate is dropped, out_data is unchanged, and overrun <= 1.
- Output handshake:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1. With no simultaneous completion, out_valid <= 0.
  - out_data holds its value after transfer and changes only on a load.
  - out_ready while out_valid=0 has no effect.
- clear (synchronous):
  - shift_reg <= 0, bit_cnt <= 0, overrun <= 0.
  - clear has priority over en_shift in the same cycle; that bit is discarded.
  - out_data and out_valid are unaffected, and a handshake in the same cycle still completes.
- Idle: en_shift=0 leaves shift_reg and bit_cnt unchanged indefinitely.
- Derived outputs:
  - busy = (bit_cnt != 0), combinational from the register.
  - overrun clears only on clear or reset.
- Streaming: strobes on every cycle are legal. Consecutive words with out_ready held at 1 produce out_valid pulses with no loss.

Test Plan:
- LSB-first: WIDTH=8, right_left=1, serial bits 1,0,1,0,0,1,0,1 (LSB first of 0xA5), out_ready=0 -> one cycle after the 8th strobe, out_valid=1 and out_data=0xA5; busy is 1 during the strobes and 0 after.
- MSB-first: right_left=0, bits of 0x3C MSB-first, with idle cycles inserted between strobes -> out_data=0x3C; bit_cnt steps 1..7 and then 0.
- Direction ignored mid-word: start LSB-first, toggle right_left after bit 3, send 0x81 -> out_data=0x81.
- Overrun: send 0x11 and hold out_ready=0, then send 0x22 -> out_data stays 0x11 and overrun=1. Pulse out_ready -> out_valid=0. Pulse clear -> overrun=0.
- Simultaneous complete and accept: out_valid=1 holding 0x11, and the 8th strobe of 0x22 lands with out_ready=1 -> out_data=0x22, out_valid stays 1, overrun stays 0.
- Abort and reset:
  - clear asserted together with the 5th strobe -> bit_cnt=0, and the next 8 bits form a clean word.
  - rst_n low mid-word (bit_cnt=3) with out_valid=1 -> all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out receiver with selectable bit order and a valid/ready holding register
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_shift,
    input  logic                       serial_in,
    input  logic                       right_left,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun
);
    localparam int CW = $clog2(WIDTH+1);
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic             dir_lat;
    logic             dir;
    logic             cap;
    logic             last;
    logic             load;
    logic             drop;
    // first bit of a word takes its order straight from right_left, later bits from the latch
    always_comb begin
        cap     = en_shift & ~clear;
        dir     = (bit_cnt == '0) ? right_left : dir_lat;
        shifted = dir ? {serial_in, shift_reg[WIDTH-1:1]} : {shift_reg[WIDTH-2:0], serial_in};
        last    = cap && (bit_cnt == CW'(WIDTH-1));
        load    = last && (!out_valid || out_ready);
        drop    = last && out_valid && !out_ready;
    end
    // word assembly, holding register and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            dir_lat   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            shift_reg <= clear ? '0 : cap ? shifted : shift_reg;
            bit_cnt   <= clear ? '0 : cap ? (last ? '0 : bit_cnt + CW'(1)) : bit_cnt;
            dir_lat   <= (cap && bit_cnt == '0) ? right_left : dir_lat;
            out_data  <= load ? shifted : out_data;
            out_valid <= load ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
            overrun   <= clear ? 1'b0 : drop ? 1'b1 : overrun;
        end
    end
    assign busy = (bit_cnt != '0);
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed and randomized checks of sipo_deser against a bit-placement model
module tb_sipo_deser;
    localparam int W  = 8;
    localparam int CW = $clog2(W+1);
    logic          clk = 0;
    logic          rst_n = 0;
    logic          en_shift = 0, serial_in = 0, right_left = 0, clear = 0, out_ready = 0;
    logic [W-1:0]  out_data;
    logic          out_valid, busy, overrun;
    logic [CW-1:0] bit_cnt;
    int            n_chk = 0, n_pass = 0;
    bit            cmp_on = 0;
    // model state: bits collected so far are placed directly at their word position
    int            m_n;
    bit            m_dir;
    logic [W-1:0]  m_word, m_data;
    bit            m_valid, m_over;

    sipo_deser #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en_shift(en_shift), .serial_in(serial_in),
        .right_left(right_left), .clear(clear), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .busy(busy),
        .bit_cnt(bit_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_dir = 0; m_word = '0; m_data = '0; m_valid = 0; m_over = 0;
    endtask

    task automatic model_step();
        bit newload, xfer;
        int pos;
        newload = 0;
        xfer = m_valid && out_ready;
        if (clear) begin
            m_n = 0; m_word = '0; m_over = 0;
        end else if (en_shift) begin
            if (m_n == 0) m_dir = right_left;
            pos = m_dir ? m_n : W-1-m_n;
            m_word[pos] = serial_in;
            m_n++;
            if (m_n == W) begin
                if (!m_valid || out_ready) begin m_data = m_word; newload = 1; end
                else m_over = 1;
                m_n = 0; m_word = '0;
            end
        end
        m_valid = newload ? 1'b1 : xfer ? 1'b0 : m_valid;
    endtask

    // one clock: drive inputs, let the edge happen, advance the model, return at the falling edge
    task automatic cyc(input bit en, input bit sin, input bit rl, input bit clr, input bit rdy);
        en_shift = en; serial_in = sin; right_left = rl; clear = clr; out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] word, input bit rl, input bit rdy_last, input bit rdy_other);
        for (int i = 0; i < W; i++)
            cyc(1, rl ? word[i] : word[W-1-i], rl, 0, (i == W-1) ? rdy_last : rdy_other);
    endtask

    // every falling edge: outputs must match the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_over));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_n));
            chk("busy", 32'(busy), 32'(m_n != 0));
        end
    end

    initial begin
        logic [W-1:0] v;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("reset_data", 32'(out_data), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        cmp_on = 1;
        // LSB-first 0xA5
        v = 8'hA5;
        for (int i = 0; i < W; i++) begin
            cyc(1, v[i], 1, 0, 0);
            if (i < W-1) chk("a5_busy", 32'(busy), 1);
        end
        chk("a5_data", 32'(out_data), 32'hA5);
        chk("a5_model", 32'(m_data), 32'hA5);
        chk("a5_valid", 32'(out_valid), 1);
        chk("a5_busy_after", 32'(busy), 0);
        cyc(0, 0, 0, 0, 1);
        chk("a5_consumed", 32'(out_valid), 0);
        // MSB-first 0x3C with idle gaps
        v = 8'h3C;
        for (int i = W-1; i >= 0; i--) begin
            cyc(1, v[i], 0, 0, 0);
            chk("3c_cnt", 32'(bit_cnt), 32'((W - i) % W));
            cyc(0, 0, 1, 0, 0);
        end
        chk("3c_data", 32'(out_data), 32'h3C);
        chk("3c_model", 32'(m_data), 32'h3C);
        cyc(0, 0, 0, 0, 1);
        // direction toggled mid-word is ignored
        v = 8'h81;
        for (int i = 0; i < W; i++) cyc(1, v[i], i < 3, 0, 0);
        chk("81_data", 32'(out_data), 32'h81);
        cyc(0, 0, 0, 0, 1);
        v = 8'hB2;
        for (int i = 0; i < W; i++) cyc(1, v[i], i < 3, 0, 0);
        chk("b2_data", 32'(out_data), 32'hB2);
        cyc(0, 0, 0, 0, 1);
        // overrun
        send(8'h11, 1, 0, 0);
        send(8'h22, 1, 0, 0);
        chk("ovr_data", 32'(out_data), 32'h11);
        chk("ovr_flag", 32'(overrun), 1);
        cyc(0, 0, 0, 0, 1);
        chk("ovr_consumed", 32'(out_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        cyc(0, 0, 0, 1, 0);
        chk("ovr_cleared", 32'(overrun), 0);
        // simultaneous completion and accept
        send(8'h11, 1, 0, 0);
        send(8'h22, 1, 1, 0);
        chk("sim_data", 32'(out_data), 32'h22);
        chk("sim_valid", 32'(out_valid), 1);
        chk("sim_ovr", 32'(overrun), 0);
        cyc(0, 0, 0, 0, 1);
        // clear together with the 5th strobe
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 0);
        chk("clr_cnt", 32'(bit_cnt), 0);
        send(8'h5A, 1, 0, 0);
        chk("clr_word", 32'(out_data), 32'h5A);
        // async reset mid-word with a held word
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        chk("rst_pre_cnt", 32'(bit_cnt), 3);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("arst_data", 32'(out_data), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_cnt", 32'(bit_cnt), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ovr", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1;
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
                $urandom_range(0, 99) < 3, 1'($urandom));
        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
